// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order FIFO between rename and the reservation stations/ROB.
// Define DISPATCH_BYPASS_EN to let a packet offered to an empty queue dispatch in the same cycle.
module dispatch_queue #(
    parameter int DEPTH  = 4,
    parameter int NUM_RS = 3,
    parameter int PKT_W  = 64,
    localparam int FU_W  = $clog2(NUM_RS),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PKT_W-1:0]  in_pkt,
    input  logic [FU_W-1:0]   in_fu,
    input  logic [NUM_RS-1:0] rs_ready_i,
    output logic [NUM_RS-1:0] rs_valid_o,
    output logic [PKT_W-1:0]  rs_pkt_o,
    input  logic              rob_ready_i,
    output logic              rob_alloc_valid_o,
    output logic [PKT_W-1:0]  rob_alloc_pkt_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [15:0]       stall_cnt_o,
    output logic              fu_err_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PKT_W-1:0] pktMem_q [DEPTH];
    logic [FU_W-1:0]  fuMem_q  [DEPTH];

    logic [PTR_W-1:0] headPtr_q, headPtr_d;
    logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      stallCnt_q, stallCnt_d;
    logic             fuErr_q, fuErr_d;

    logic             headValid;
    logic [PKT_W-1:0] headPkt;
    logic [FU_W-1:0]  headFu;
    logic             headFuOk;

    logic             bypassSel;
    logic             candValid;
    logic [PKT_W-1:0] candPkt;
    logic [FU_W-1:0]  candFu;
    logic             candFuOk;
    logic             candRsReady;

    logic             fire;
    logic             push;
    logic             pushStore;
    logic             pop;

    assign headValid = (count_q != '0);
    assign headPkt   = pktMem_q[headPtr_q];
    assign headFu    = fuMem_q[headPtr_q];

    // The dispatch candidate is the head entry, or the incoming packet when bypassing an empty queue.
`ifdef DISPATCH_BYPASS_EN
    assign bypassSel = (count_q == '0) && in_valid;
    assign candValid = headValid || bypassSel;
    assign candPkt   = bypassSel ? in_pkt : headPkt;
    assign candFu    = bypassSel ? in_fu : headFu;
`else
    assign bypassSel = 1'b0;
    assign candValid = headValid;
    assign candPkt   = headPkt;
    assign candFu    = headFu;
`endif

    always_comb begin
        candFuOk    = 1'b0;
        candRsReady = 1'b0;
        headFuOk    = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (candFu == FU_W'(i)) begin
                candFuOk    = 1'b1;
                candRsReady = rs_ready_i[i];
            end
            if (headFu == FU_W'(i)) begin
                headFuOk = 1'b1;
            end
        end
    end

    assign fire      = candValid && candFuOk && candRsReady && rob_ready_i && !flush_i && !rst;
    assign in_ready  = (count_q != CNT_W'(DEPTH)) && !flush_i && !rst;
    assign push      = in_valid && in_ready;
    assign pushStore = push && !(bypassSel && fire);
    assign pop       = fire && !bypassSel;

    always_comb begin
        rs_valid_o = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            rs_valid_o[i] = fire && (candFu == FU_W'(i));
        end
    end

    assign rob_alloc_valid_o = fire;
    assign rs_pkt_o          = candValid ? candPkt : '0;
    assign rob_alloc_pkt_o   = candValid ? candPkt : '0;
    assign count_o           = count_q;
    assign stall_cnt_o       = stallCnt_q;
    assign fu_err_o          = fuErr_q;

    always_comb begin
        headPtr_d  = headPtr_q;
        tailPtr_d  = tailPtr_q;
        count_d    = count_q;
        stallCnt_d = stallCnt_q;
        fuErr_d    = fuErr_q;
        if (flush_i) begin
            headPtr_d = '0;
            tailPtr_d = '0;
            count_d   = '0;
            fuErr_d   = 1'b0;
        end else begin
            if (pushStore) begin
                tailPtr_d = tailPtr_q + PTR_W'(1);
            end
            if (pop) begin
                headPtr_d = headPtr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(pushStore) - CNT_W'(pop);
            if (headValid && !fire && (stallCnt_q != 16'hFFFF)) begin
                stallCnt_d = stallCnt_q + 16'd1;
            end
            // A head aimed at a nonexistent RS can never fire; flag it until flushed.
            if (headValid && !headFuOk) begin
                fuErr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr_q  <= '0;
            tailPtr_q  <= '0;
            count_q    <= '0;
            stallCnt_q <= '0;
            fuErr_q    <= 1'b0;
        end else begin
            headPtr_q  <= headPtr_d;
            tailPtr_q  <= tailPtr_d;
            count_q    <= count_d;
            stallCnt_q <= stallCnt_d;
            fuErr_q    <= fuErr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushStore) begin
            pktMem_q[tailPtr_q] <= in_pkt;
            fuMem_q[tailPtr_q]  <= in_fu;
        end
    end

endmodule
